// File: rtl/noc_traffic_gen.sv
// NoC packet source: header flit, LFSR payload and optional inter-packet gap on one link.
// Optional checksum trailer flit is built when NOC_TRAFFIC_GEN_CHECKSUM_EN is defined.
module noc_traffic_gen #(
    parameter logic [4:0]  SRC_ID    = 5'd0,
    parameter int          LEN_WIDTH = 4,
    parameter int          CNT_WIDTH = 16,
    parameter int          GAP_WIDTH = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4:0]           cfg_dest,
    input  logic [2:0]           cfg_class,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [CNT_WIDTH-1:0] cfg_num,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic                 abort,
    output logic [33:0]          out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

`ifdef NOC_TRAFFIC_GEN_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [GAP_WIDTH-1:0] GAP_ZERO = {GAP_WIDTH{1'b0}};
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_GAP  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Sequence number is the packet count, zero-extended or truncated to 19 bits.
    function automatic logic [31:0] hdr_word(input logic [4:0] dest, input logic [2:0] cls,
                                             input logic [CNT_WIDTH-1:0] seq);
        logic [CNT_WIDTH+18:0] ext;
        ext = {{19{1'b0}}, seq};
        return {dest, cls, SRC_ID, ext[18:0]};
    endfunction

    state_t               state_r;
    logic [4:0]           dest_r;
    logic [2:0]           class_r;
    logic [LEN_WIDTH-1:0] len_r;
    logic [CNT_WIDTH-1:0] num_r;
    logic [GAP_WIDTH-1:0] gap_r;
    logic [GAP_WIDTH-1:0] gap_cnt_r;
    logic [LEN_WIDTH-1:0] pay_cnt_r;
    logic [31:0]          lfsr_r;
    logic [31:0]          csum_r;
    logic                 abort_r;

    logic                 xfer_s;
    logic                 eop_s;
    logic                 end_run_s;
    logic                 hdr_last_s;
    logic                 last_pay_s;
    logic                 next_last_s;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic [LEN_WIDTH-1:0] pay_cnt_inc_s;
    logic [31:0]          lfsr_nxt_s;
    logic [31:0]          csum_nxt_s;

    // Handshake, end-of-packet and end-of-run decode
    always_comb begin
        xfer_s        = out_valid & out_ready;
        cnt_inc_s     = pkt_cnt + CNT_ONE;
        pay_cnt_inc_s = pay_cnt_r + LEN_ONE;
        lfsr_nxt_s    = lfsr_step(lfsr_r);
        csum_nxt_s    = csum_r ^ lfsr_r;
        last_pay_s    = (pay_cnt_r == len_r);
        next_last_s   = (pay_cnt_inc_s == len_r) & ~CHK_EN;
        hdr_last_s    = (len_r == LEN_ZERO) & ~CHK_EN;
        end_run_s     = (cnt_inc_s == num_r) | abort_r | abort;
        eop_s         = 1'b0;
        case (state_r)
            ST_HDR:  eop_s = xfer_s & hdr_last_s;
            ST_PAY:  eop_s = xfer_s & last_pay_s & ~CHK_EN;
            ST_CHK:  eop_s = xfer_s;
            default: eop_s = 1'b0;
        endcase
    end

    // Generator FSM; flit, status and datapath state are all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            dest_r    <= 5'd0;
            class_r   <= 3'd0;
            len_r     <= LEN_ZERO;
            num_r     <= CNT_ZERO;
            gap_r     <= GAP_ZERO;
            gap_cnt_r <= GAP_ZERO;
            pay_cnt_r <= LEN_ZERO;
            lfsr_r    <= LFSR_SEED;
            csum_r    <= 32'd0;
            abort_r   <= 1'b0;
            out_flit  <= 34'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_cnt   <= CNT_ZERO;
        end else begin
            done <= 1'b0;
            if (state_r != ST_IDLE) begin
                abort_r <= abort_r | abort;
            end
            if (eop_s) begin
                pkt_cnt <= cnt_inc_s;
                if (state_r == ST_PAY) begin
                    lfsr_r <= lfsr_nxt_s;
                end
                if (end_run_s) begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_flit  <= 34'd0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else if (gap_r != GAP_ZERO) begin
                    state_r   <= ST_GAP;
                    gap_cnt_r <= gap_r;
                    out_valid <= 1'b0;
                    out_flit  <= 34'd0;
                end else begin
                    // Back-to-back: next header goes out with no bubble.
                    state_r   <= ST_HDR;
                    out_valid <= 1'b1;
                    out_flit  <= {hdr_last_s, 1'b1, hdr_word(dest_r, class_r, cnt_inc_s)};
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            if (cfg_num == CNT_ZERO) begin
                                done <= 1'b1;
                            end else begin
                                dest_r    <= cfg_dest;
                                class_r   <= cfg_class;
                                len_r     <= cfg_len;
                                num_r     <= cfg_num;
                                gap_r     <= cfg_gap;
                                pkt_cnt   <= CNT_ZERO;
                                lfsr_r    <= LFSR_SEED;
                                abort_r   <= 1'b0;
                                busy      <= 1'b1;
                                state_r   <= ST_HDR;
                                out_valid <= 1'b1;
                                out_flit  <= {(cfg_len == LEN_ZERO) & ~CHK_EN, 1'b1,
                                              hdr_word(cfg_dest, cfg_class, CNT_ZERO)};
                            end
                        end
                    end
                    ST_HDR: begin
                        if (xfer_s) begin
                            pay_cnt_r <= LEN_ONE;
                            csum_r    <= 32'd0;
                            if (len_r == LEN_ZERO) begin
                                state_r  <= ST_CHK;
                                out_flit <= {2'b10, 32'd0};
                            end else begin
                                state_r  <= ST_PAY;
                                out_flit <= {(len_r == LEN_ONE) & ~CHK_EN, 1'b0, lfsr_r};
                            end
                        end
                    end
                    ST_PAY: begin
                        if (xfer_s) begin
                            lfsr_r <= lfsr_nxt_s;
                            csum_r <= csum_nxt_s;
                            if (last_pay_s) begin
                                state_r  <= ST_CHK;
                                out_flit <= {2'b10, csum_nxt_s};
                            end else begin
                                pay_cnt_r <= pay_cnt_inc_s;
                                out_flit  <= {next_last_s, 1'b0, lfsr_nxt_s};
                            end
                        end
                    end
                    ST_CHK: begin
                        state_r <= ST_CHK;
                    end
                    ST_GAP: begin
                        if (abort_r | abort) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (gap_cnt_r == GAP_ONE) begin
                            state_r   <= ST_HDR;
                            out_valid <= 1'b1;
                            out_flit  <= {hdr_last_s, 1'b1, hdr_word(dest_r, class_r, pkt_cnt)};
                        end else begin
                            gap_cnt_r <= gap_cnt_r - GAP_ONE;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_flit  <= 34'd0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Scoreboard bench for noc_traffic_gen: a packet-level model fills an expected-flit queue,
// a monitor pops and compares on every link transfer. Honours NOC_TRAFFIC_GEN_CHECKSUM_EN.
module tb_noc_traffic_gen;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [4:0]  SRC  = 5'd0;
`ifdef NOC_TRAFFIC_GEN_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_dest = 5'd0;
    logic [2:0]  cfg_class = 3'd0;
    logic [3:0]  cfg_len = 4'd0;
    logic [15:0] cfg_num = 16'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic        abort = 1'b0;
    logic [33:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [33:0] exp_q[$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    bit          rec_en = 1'b0;
    bit          vhist[$];
    bit          prev_stall = 1'b0;
    logic [33:0] prev_flit = 34'd0;

    noc_traffic_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_dest(cfg_dest), .cfg_class(cfg_class),
        .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_gap(cfg_gap), .abort(abort),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Router-side ready: always on, 1-on/3-off, or random
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0);
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Monitor: scoreboard pop on transfer, hold-stable check while stalled
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 64'd1);
                check("hold_flit", out_flit, prev_flit);
            end
            if (rec_en) vhist.push_back(out_valid);
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_flit: got %h expected none", out_flit);
                end else begin
                    check("flit", out_flit, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = out_flit;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Expected flit stream of a whole run of npk packets
    task automatic push_model(input logic [4:0] dest, input logic [2:0] cls, input int len, input int npk);
        logic [31:0] l;
        logic [31:0] x;
        logic [18:0] s;
        l = SEED;
        for (int p = 0; p < npk; p++) begin
            s = 19'(p);
            exp_q.push_back({(len == 0) && !CHK, 1'b1, dest, cls, SRC, s});
            x = 32'd0;
            for (int i = 1; i <= len; i++) begin
                exp_q.push_back({(i == len) && !CHK, 1'b0, l});
                x = x ^ l;
                l = lfsr_adv(l);
            end
            if (CHK) exp_q.push_back({2'b10, x});
        end
    endtask

    task automatic run(input logic [4:0] dest, input logic [2:0] cls, input int len, input int num,
                       input int gap, input int exp_cnt, input int abort_xfer, input int abort_wait,
                       input int rmode);
        int t;
        int base;
        int wcnt;
        bit fired;
        ready_mode = rmode;
        done_cnt   = 0;
        base       = xfer_cnt;
        wcnt       = abort_wait;
        fired      = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; cfg_dest = dest; cfg_class = cls;
        cfg_len = len[3:0]; cfg_num = num[15:0]; cfg_gap = gap[7:0];
        @(posedge clk); #1;
        check("busy_after_start", busy, 64'(num != 0));
        // Scrambled config plus a second start pulse while busy must be ignored
        cfg_dest = 5'($urandom); cfg_class = 3'($urandom); cfg_len = 4'($urandom);
        cfg_num = 16'($urandom); cfg_gap = 8'($urandom);
        start = (num != 0);
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            if (abort_xfer >= 0 && !fired && (xfer_cnt - base) >= abort_xfer) begin
                if (wcnt == 0) begin
                    abort = 1'b1;
                    fired = 1'b1;
                end else begin
                    wcnt--;
                end
            end else begin
                abort = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        abort = 1'b0;
        if (t >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 4000 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 64'd1);
        check("busy_end", busy, 64'd0);
        check("pkt_cnt", pkt_cnt, 64'(exp_cnt[15:0]));
        check("flits_left", exp_q.size(), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_pattern(input string name, input int len, input int num, input int gap);
        bit e[$];
        int f;
        int a;
        int b;
        f = 1 + len + int'(CHK);
        for (int p = 0; p < num; p++) begin
            for (int i = 0; i < f; i++) e.push_back(1'b1);
            if (p < num - 1) for (int i = 0; i < gap; i++) e.push_back(1'b0);
        end
        a = 0;
        while (a < vhist.size() && vhist[a] == 1'b0) a++;
        b = vhist.size() - 1;
        while (b >= a && vhist[b] == 1'b0) b--;
        check({name, "_len"}, 64'(b - a + 1), 64'(e.size()));
        for (int i = 0; i < e.size() && (a + i) <= b; i++) check(name, 64'(vhist[a + i]), 64'(e[i]));
    endtask

    initial begin
        int t;
        int base;
        int rl;
        int rn;
        logic [4:0] rd;
        logic [2:0] rc;
        #12;
        check("rst_valid", out_valid, 64'd0);
        check("rst_flit", out_flit, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_pkt_cnt", pkt_cnt, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Single packet against hand-derived flit values
`ifdef NOC_TRAFFIC_GEN_CHECKSUM_EN
        exp_q.push_back({2'b01, 32'h1800_0000});
        exp_q.push_back({2'b00, 32'hACE1_2468});
        exp_q.push_back({2'b00, 32'h59C2_48D0});
        exp_q.push_back({2'b10, 32'hF523_6CB8});
`else
        exp_q.push_back({2'b01, 32'h1800_0000});
        exp_q.push_back({2'b00, 32'hACE1_2468});
        exp_q.push_back({2'b10, 32'h59C2_48D0});
`endif
        run(5'd3, 3'd0, 2, 1, 0, 1, -1, 0, 0);

        // Same packet under 1-on/3-off backpressure
        push_model(5'd3, 3'd0, 2, 1);
        run(5'd3, 3'd0, 2, 1, 0, 1, -1, 0, 1);

        // Gap and back-to-back valid patterns with sequence numbers 0..2
        vhist.delete(); rec_en = 1'b1;
        push_model(5'd1, 3'd2, 0, 3);
        run(5'd1, 3'd2, 0, 3, 4, 3, -1, 0, 0);
        rec_en = 1'b0;
        check_pattern("gap4_pattern", 0, 3, 4);
        vhist.delete(); rec_en = 1'b1;
        push_model(5'd1, 3'd2, 0, 3);
        run(5'd1, 3'd2, 0, 3, 0, 3, -1, 0, 0);
        rec_en = 1'b0;
        check_pattern("gap0_pattern", 0, 3, 0);

        // Abort during packet 0: packet completes, then stop
        push_model(5'd5, 3'd1, 5, 1);
        run(5'd5, 3'd1, 5, 10, 0, 1, 1, 0, 0);

        // Abort during an inter-packet gap
        push_model(5'd2, 3'd3, 1, 1);
        run(5'd2, 3'd3, 1, 5, 20, 1, 2 + int'(CHK), 3, 0);

        // Zero packets: done only, pkt_cnt keeps its previous value
        run(5'd4, 3'd4, 3, 0, 0, 1, -1, 0, 0);

        // Randomized runs
        for (int k = 0; k < 8; k++) begin
            rd = 5'($urandom);
            rc = 3'($urandom);
            rl = $urandom_range(0, 15);
            rn = $urandom_range(1, 4);
            push_model(rd, rc, rl, rn);
            run(rd, rc, rl, rn, $urandom_range(0, 3), rn, -1, 0, $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a packet
        ready_mode = 1;
        base = xfer_cnt;
        push_model(5'd9, 3'd6, 8, 5);
        @(posedge clk); #1;
        start = 1'b1; cfg_dest = 5'd9; cfg_class = 3'd6; cfg_len = 4'd8; cfg_num = 16'd5; cfg_gap = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (((xfer_cnt - base) < 3 || !out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL midpkt_timeout: got no progress expected 3 transfers");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 64'd0);
        check("async_rst_busy", busy, 64'd0);
        check("async_rst_cnt", pkt_cnt, 64'd0);
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        push_model(5'd9, 3'd6, 3, 2);
        run(5'd9, 3'd6, 3, 2, 1, 2, -1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
